uart_tx_scheduler: RTL

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler_pkg.sv | 27 ++
 rtl/rr_arbiter4.sv | 35 +++
 rtl/uart_tx_scheduler.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_tx_scheduler_pkg;

    // Only a four-way requester set is built; the arbiter is hard-wired for it.
    localparam int NREQ_SUPPORTED = 4;

    // Upper nibble that marks a byte on the wire as a header.
    localparam logic [3:0] HDR_TAG_DEFAULT = 4'hA;

    // Transaction sequencer states, 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HDR_ISSUE = 3'd1,
        HDR_WAIT  = 3'd2,
        PLD_ISSUE = 3'd3,
        PLD_WAIT  = 3'd4,
        DONE      = 3'd5
    } state_t;

    // Converts a requester index into its ack bit position.
    function automatic logic [3:0] id_onehot(input logic [1:0] id);
        return 4'b0001 << id;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin pick: first asserted req at or above ptr, wrapping.
// Latency: zero cycles, purely combinational.
// Backpressure: none; caller decides when to consume the winner.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] winner,
    output logic       valid
);

    logic [7:0] req_dbl;
    logic [3:0] req_rot;
    logic [1:0] offset;

    // Duplicate and slice so that bit 0 of req_rot is always the requester at ptr.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: 4];

    // Priority-encode the rotated vector: lowest set bit is the closest requester to ptr.
    always_comb begin
        offset = 2'd0;
        casez (req_rot)
            4'b???1: offset = 2'd0;
            4'b??10: offset = 2'd1;
            4'b?100: offset = 2'd2;
            4'b1000: offset = 2'd3;
            default: offset = 2'd0;
        endcase
    end

    // Undo the rotation; the 2-bit add wraps modulo 4 naturally.
    assign winner = ptr + offset;
    assign valid  = |req;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART sender between four requesters: header byte then payload byte per grant.
// Latency: arbitration in IDLE, header issued the next cycle; ack one cycle after payload completes.
// Backpressure: ISSUE states hold until tx_ready; WAIT states hold until the sender is idle again.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter logic [3:0] HDR_TAG = HDR_TAG_DEFAULT,
    parameter int         NREQ    = NREQ_SUPPORTED
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic              busy,
    output logic [7:0]        tx_data,
    output logic              tx_en,
    input  logic              tx_ready
);

    state_t          state_q;
    state_t          state_d;
    logic [1:0]      ptr_q;
    logic [1:0]      id_q;
    logic [7:0]      payload_q;
    logic [NREQ-1:0] ack_q;
    // Set for the first cycle of a WAIT state, when tx_ready still reflects the
    // sender before it saw our strobe and must not be trusted.
    logic            wait_first_q;

    logic [1:0]      win_id;
    logic            win_vld;

    rr_arbiter4 u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .winner (win_id),
        .valid  (win_vld)
    );

    // Next-state and strobe: issue only when the sender is idle, then wait for it to finish.
    always_comb begin
        state_d = state_q;
        tx_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = HDR_ISSUE;
                end
            end
            HDR_ISSUE: begin
                if (tx_ready) begin
                    tx_en   = 1'b1;
                    state_d = HDR_WAIT;
                end
            end
            HDR_WAIT: begin
                if (!wait_first_q && tx_ready) begin
                    state_d = PLD_ISSUE;
                end
            end
            PLD_ISSUE: begin
                if (tx_ready) begin
                    tx_en   = 1'b1;
                    state_d = PLD_WAIT;
                end
            end
            PLD_WAIT: begin
                if (!wait_first_q && tx_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Byte on the sender bus: header while the header is in flight, payload while the payload is.
    always_comb begin
        tx_data = 8'h00;
        case (state_q)
            HDR_ISSUE, HDR_WAIT: tx_data = {HDR_TAG, 2'b00, id_q};
            PLD_ISSUE, PLD_WAIT: tx_data = payload_q;
            default:             tx_data = 8'h00;
        endcase
    end

    // State register plus the first-WAIT-cycle marker, which follows every accepted strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wait_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_first_q <= tx_en;
        end
    end

    // Latch winner id and its payload byte at grant so later req/req_data changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_q      <= 2'd0;
            payload_q <= 8'h00;
        end else if (state_q == IDLE && win_vld) begin
            id_q      <= win_id;
            payload_q <= req_data[{win_id, 3'b000} +: 8];
        end
    end

    // Advance the round-robin pointer past the requester just served.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 2'd0;
        end else if (state_q == DONE) begin
            ptr_q <= id_q + 2'd1;
        end
    end

    // Ack is registered so it is high exactly while the FSM sits in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q <= '0;
        end else if (state_q == PLD_WAIT && state_d == DONE) begin
            ack_q <= id_onehot(id_q);
        end else begin
            ack_q <= '0;
        end
    end

    assign ack  = ack_q;
    assign busy = (state_q != IDLE);

endmodule
